set_button_conditioner: RTL and testbench

- Produces the time-setting increment pulses for the clock core: the single-cycle inc_hours / inc_minutes strobes that the core consumes while in set mode.
- Conditions two raw DE10-Lite push-buttons: synchronise, debounce, detect the press, then auto-repeat while the button is held.
- Sits between the board KEY pins and the clock core's hour/minute set inputs.
- Guarantees exactly one increment per physical press plus paced repeats, never one increment per clock cycle.

---
 rtl/set_button_conditioner.sv | 173 +++++++++++++++++
 tb/tb_set_button_conditioner.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/set_button_conditioner.sv
// Turns the two raw set-mode push-buttons into paced single-cycle increment strobes:
// synchronise, debounce, one strobe per press, then delayed auto-repeat while held.
module set_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES     = 32'd1000000,
    parameter int unsigned REPEAT_DELAY_CYCLES = 32'd25000000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 32'd5000000,
    parameter bit          ACTIVE_LOW          = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic key_hours_raw,
    input  logic key_minutes_raw,
    output logic inc_hours,
    output logic inc_minutes,
    output logic pressed_hours,
    output logic pressed_minutes
);

    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
    localparam int unsigned RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                     REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int unsigned RP_W   = (RP_MAX > 32'd1) ? $clog2(RP_MAX) : 32'd1;

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY_CYCLES - 32'd1);
    localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE_CYCLES - 32'd1);
    localparam logic            RELEASED   = ACTIVE_LOW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    logic [1:0] key_raw_s;
    logic [1:0] inc_s;
    logic [1:0] pressed_s;

    assign key_raw_s = {key_minutes_raw, key_hours_raw};

    genvar ch;
    for (ch = 0; ch < 2; ch++) begin : g_chan
        logic [1:0]      sync_q, sync_d;
        logic            lvl_q, lvl_d;
        logic [DB_W-1:0] db_cnt_q, db_cnt_d;
        logic            pressed_q, pressed_d;
        logic            arm_q, arm_d;
        state_e          state_q, state_d;
        logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
        logic            inc_q, inc_d;
        logic            rise_s;

        // Synchroniser, polarity normalisation (1 = pressed), debounce and arm tracking
        always_comb begin
            sync_d    = {sync_q[0], key_raw_s[ch]};
            lvl_d     = sync_q[1] ^ ACTIVE_LOW;
            pressed_d = pressed_q;
            db_cnt_d  = '0;
            if (lvl_q != pressed_q) begin
                if (db_cnt_q == DB_LAST) begin
                    pressed_d = ~pressed_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_d = '0;
            end
            // A press that debounces while set mode is off must be released before it counts
            if (!pressed_q) begin
                arm_d = 1'b1;
            end else if (!enable) begin
                arm_d = 1'b0;
            end else begin
                arm_d = arm_q;
            end
            rise_s = pressed_d & ~pressed_q;
        end

        // State register and all channel flops
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q    <= {2{RELEASED}};
                lvl_q     <= 1'b0;
                db_cnt_q  <= '0;
                pressed_q <= 1'b0;
                arm_q     <= 1'b1;
                state_q   <= ST_IDLE;
                rp_cnt_q  <= '0;
                inc_q     <= 1'b0;
            end else begin
                sync_q    <= sync_d;
                lvl_q     <= lvl_d;
                db_cnt_q  <= db_cnt_d;
                pressed_q <= pressed_d;
                arm_q     <= arm_d;
                state_q   <= state_d;
                rp_cnt_q  <= rp_cnt_d;
                inc_q     <= inc_d;
            end
        end

        // Next-state and repeat counter
        always_comb begin
            state_d  = state_q;
            rp_cnt_d = rp_cnt_q;
            if (!enable) begin
                state_d  = ST_IDLE;
                rp_cnt_d = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        rp_cnt_d = '0;
                        if (rise_s && arm_q) begin
                            state_d = ST_DELAY;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_DELAY: begin
                        if (!pressed_d) begin
                            state_d  = ST_IDLE;
                            rp_cnt_d = '0;
                        end else if (rp_cnt_q == DELAY_LAST) begin
                            state_d  = ST_REPEAT;
                            rp_cnt_d = '0;
                        end else begin
                            rp_cnt_d = rp_cnt_q + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!pressed_d) begin
                            state_d  = ST_IDLE;
                            rp_cnt_d = '0;
                        end else if (rp_cnt_q == RATE_LAST) begin
                            rp_cnt_d = '0;
                        end else begin
                            rp_cnt_d = rp_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d  = ST_IDLE;
                        rp_cnt_d = '0;
                    end
                endcase
            end
        end

        // Strobe generation, registered so it lands on the same edge as the state change
        always_comb begin
            inc_d = 1'b0;
            if (enable) begin
                case (state_q)
                    ST_IDLE:   inc_d = rise_s & arm_q;
                    ST_DELAY:  inc_d = pressed_d & (rp_cnt_q == DELAY_LAST);
                    ST_REPEAT: inc_d = pressed_d & (rp_cnt_q == RATE_LAST);
                    default:   inc_d = 1'b0;
                endcase
            end else begin
                inc_d = 1'b0;
            end
        end

        assign inc_s[ch]     = inc_q & enable;
        assign pressed_s[ch] = pressed_q;
    end

    assign inc_hours       = inc_s[0];
    assign inc_minutes     = inc_s[1];
    assign pressed_hours   = pressed_s[0];
    assign pressed_minutes = pressed_s[1];

endmodule

// File: tb/tb_set_button_conditioner.sv
// Directed bench for set_button_conditioner with short debounce/repeat parameters:
// a per-cycle vector table for press/bounce timing plus hand sequences for repeat, gating and reset.
module tb_set_button_conditioner;

    logic clk;
    logic reset;
    logic enable;
    logic key_hours_raw;
    logic key_minutes_raw;
    logic inc_hours;
    logic inc_minutes;
    logic pressed_hours;
    logic pressed_minutes;

    set_button_conditioner #(
        .DEBOUNCE_CYCLES    (4),
        .REPEAT_DELAY_CYCLES(20),
        .REPEAT_RATE_CYCLES (5),
        .ACTIVE_LOW         (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .key_hours_raw  (key_hours_raw),
        .key_minutes_raw(key_minutes_raw),
        .inc_hours      (inc_hours),
        .inc_minutes    (inc_minutes),
        .pressed_hours  (pressed_hours),
        .pressed_minutes(pressed_minutes)
    );

    typedef struct {
        logic kh;
        logic km;
        logic eh;
        logic em;
        logic ph;
        logic pm;
    } vec_t;

    localparam int NVEC = 54;
    vec_t vecs[0:NVEC-1];

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;
    int ph_t[0:63];
    int pm_t[0:63];
    int ph_n = 0;
    int pm_n = 0;
    int exp_t[0:15];
    int exp_n = 0;
    int base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Record the edge number of every strobe seen
    always @(negedge clk) begin
        if (inc_hours) begin
            if (ph_n < 64) ph_t[ph_n] <= edge_n;
            ph_n <= ph_n + 1;
        end
        if (inc_minutes) begin
            if (pm_n < 64) pm_t[pm_n] <= edge_n;
            pm_n <= pm_n + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_trains();
        ph_n = 0;
        pm_n = 0;
    endtask

    // Compare a recorded strobe train (relative to b) against exp_t/exp_n
    task automatic chk_train(input string name, input int b, input bit ch);
        int n;
        int t;
        int tp;
        n = ch ? pm_n : ph_n;
        chk($sformatf("%s_count", name), n, exp_n);
        for (int k = 0; k < exp_n && k < n && k < 64; k++) begin
            t = ch ? pm_t[k] : ph_t[k];
            chk($sformatf("%s_pulse%0d_edge", name, k), t - b, exp_t[k]);
        end
        for (int k = 1; k < n && k < 64; k++) begin
            t  = ch ? pm_t[k] : ph_t[k];
            tp = ch ? pm_t[k-1] : ph_t[k-1];
            chk($sformatf("%s_gap%0d_gt1", name, k), (t - tp > 1) ? 1 : 0, 1);
        end
    endtask

    initial begin
        // Hours single press: low for 12 cycles, pulse 6 edges after first sampling edge
        for (int i = 0; i < 24; i++) begin
            vecs[i].kh = (i < 12) ? 1'b0 : 1'b1;
            vecs[i].km = 1'b1;
            vecs[i].eh = (i == 6) ? 1'b1 : 1'b0;
            vecs[i].em = 1'b0;
            vecs[i].ph = (i >= 6 && i < 18) ? 1'b1 : 1'b0;
            vecs[i].pm = 1'b0;
        end
        // Minutes bounce: 2-cycle toggles for 10 cycles, last falling at j=8, held to j=19
        for (int j = 0; j < 30; j++) begin
            vecs[24+j].kh = 1'b1;
            if (j < 10) vecs[24+j].km = ((j / 2) % 2 == 0) ? 1'b0 : 1'b1;
            else        vecs[24+j].km = (j < 20) ? 1'b0 : 1'b1;
            vecs[24+j].eh = 1'b0;
            vecs[24+j].em = (j == 14) ? 1'b1 : 1'b0;
            vecs[24+j].ph = 1'b0;
            vecs[24+j].pm = (j >= 14 && j < 26) ? 1'b1 : 1'b0;
        end

        reset           = 1'b1;
        enable          = 1'b1;
        key_hours_raw   = 1'b1;
        key_minutes_raw = 1'b1;
        cycles(3);
        chk("reset_inc_hours", inc_hours, 0);
        chk("reset_inc_minutes", inc_minutes, 0);
        chk("reset_pressed_hours", pressed_hours, 0);
        chk("reset_pressed_minutes", pressed_minutes, 0);
        reset = 1'b0;
        cycles(2);

        for (int i = 0; i < NVEC; i++) begin
            key_hours_raw   = vecs[i].kh;
            key_minutes_raw = vecs[i].km;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_inc_hours", i), inc_hours, vecs[i].eh);
            chk($sformatf("vec%0d_inc_minutes", i), inc_minutes, vecs[i].em);
            chk($sformatf("vec%0d_pressed_hours", i), pressed_hours, vecs[i].ph);
            chk($sformatf("vec%0d_pressed_minutes", i), pressed_minutes, vecs[i].pm);
        end

        // Auto-repeat: held 58 cycles, release debounced at +64
        cycles(1);
        clear_trains();
        key_hours_raw = 1'b0;
        base = edge_n + 1;
        cycles(58);
        key_hours_raw = 1'b1;
        cycles(15);
        exp_n = 9;
        exp_t[0] = 6;
        for (int k = 1; k < 9; k++) exp_t[k] = 26 + 5 * (k - 1);
        chk_train("repeat_hours", base, 1'b0);
        exp_n = 0;
        chk_train("repeat_minutes_idle", base, 1'b1);
        chk("repeat_released", pressed_hours, 0);

        // Simultaneous press: both trains identical
        clear_trains();
        key_hours_raw   = 1'b0;
        key_minutes_raw = 1'b0;
        base = edge_n + 1;
        cycles(33);
        key_hours_raw   = 1'b1;
        key_minutes_raw = 1'b1;
        cycles(15);
        exp_n = 4;
        exp_t[0] = 6;
        exp_t[1] = 26;
        exp_t[2] = 31;
        exp_t[3] = 36;
        chk_train("simul_hours", base, 1'b0);
        chk_train("simul_minutes", base, 1'b1);

        // Enable gating: held across enable rise gives nothing; a fresh press gives one
        clear_trains();
        enable        = 1'b0;
        key_hours_raw = 1'b0;
        cycles(15);
        chk("gate_pressed_while_disabled", pressed_hours, 1);
        enable = 1'b1;
        cycles(30);
        chk("gate_still_pressed", pressed_hours, 1);
        exp_n = 0;
        chk_train("gate_held_no_pulse", 0, 1'b0);
        key_hours_raw = 1'b1;
        cycles(12);
        key_hours_raw = 1'b0;
        base = edge_n + 1;
        cycles(10);
        key_hours_raw = 1'b1;
        cycles(12);
        exp_n = 1;
        exp_t[0] = 6;
        chk_train("gate_repress", base, 1'b0);

        // Reset mid-repeat, key still held afterwards
        clear_trains();
        key_hours_raw = 1'b0;
        base = edge_n + 1;
        cycles(32);
        chk("rst_pre_inc_hours", inc_hours, 1);
        reset = 1'b1;
        #1;
        chk("rst_async_inc_hours", inc_hours, 0);
        chk("rst_async_pressed_hours", pressed_hours, 0);
        chk("rst_async_inc_minutes", inc_minutes, 0);
        cycles(3);
        reset = 1'b0;
        clear_trains();
        base = edge_n + 1;
        cycles(12);
        key_hours_raw = 1'b1;
        cycles(12);
        exp_n = 1;
        exp_t[0] = 6;
        chk_train("rst_repress", base, 1'b0);
        chk("rst_final_pressed", pressed_hours, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
